// File: rtl/hazard_stall_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : hazard_stall_ctrl_if
// Brief  : ID-stage hazard inputs and front-end/ID-EX sequencing outputs.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_stall_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_is_md;
  logic       id_reads_hilo;
  logic       ex_memread;
  logic [4:0] ex_wr;
  logic       ex_br_taken;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       md_start;
  logic       md_busy;
  logic       md_done;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_md, id_reads_hilo,
           ex_memread, ex_wr, ex_br_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
           md_start, md_busy, md_done
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_md, id_reads_hilo,
           ex_memread, ex_wr, ex_br_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
           md_start, md_busy, md_done
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
//------------------------------------------------------------------------------
// Module : hazard_stall_ctrl
// Brief  : Load-use / branch-squash / MULT-DIV scheduling for PC, IF/ID, ID/EX.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  hz
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             lu;
  logic             mdh;
  logic             md_issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    lu = hz.ex_memread && (hz.ex_wr != 5'd0) &&
         ((hz.ex_wr == hz.id_rs) || (hz.id_uses_rt && (hz.ex_wr == hz.id_rt)));
    // HI/LO consumers may proceed in the cycle the result lands (cnt == 0).
    mdh = (hz.id_is_md || hz.id_reads_hilo) && (state == MD_RUN) && (cnt != '0);
    md_issue = hz.id_is_md && !hz.ex_br_taken && !lu && !mdh;

    state_nx = state;
    cnt_nx   = cnt;
    if (state == MD_RUN) begin
      if (cnt != '0) begin
        cnt_nx = cnt - CNT_ONE;
      end else begin
        state_nx = IDLE;
      end
    end
    if (md_issue) begin
      state_nx = MD_RUN;
      cnt_nx   = CNT_RELOAD;
    end

    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    hz.md_start    = md_issue;
    hz.md_busy     = (state == MD_RUN);
    hz.md_done     = (state == MD_RUN) && (cnt == '0);

    if (hz.ex_br_taken) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (lu || mdh) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
    end

    if (reset) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
      hz.md_start    = 1'b0;
      hz.md_busy     = 1'b0;
      hz.md_done     = 1'b0;
    end
  end

endmodule

`default_nettype wire
